// File: rtl/rob_commit_ctrl_pkg.sv
// Shared definitions for the ROB commit controller: parameter defaults and FSM state encodings.
// Tag value 0 is reserved as "no tag", so live tags run 1..2**Q_WIDTH-1.
package rob_commit_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned Q_WIDTH_DEF        = 4;
  localparam int unsigned FLUSH_CYCLES_DEF   = 2;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_e;

  // Counter width able to hold FLUSH_CYCLES-1, never narrower than one bit.
  function automatic int unsigned flush_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_flush_timer.sv
// Loadable down-counter that holds flush high for exactly FLUSH_CYCLES enabled cycles
// after a load and flags the final flush cycle on done_out.
module rob_commit_ctrl_flush_timer
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  input  logic load_in,
  output logic flush_out,
  output logic done_out
);

  localparam int unsigned CW = flush_cnt_width(FLUSH_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_flush;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else if (en_in) begin
      if (load_in) begin
        r_flush <= 1'b1;
        r_cnt   <= CW'(FLUSH_CYCLES - 1);
      end else if (r_flush) begin
        if (r_cnt == '0) begin
          r_flush <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign flush_out = r_flush;
  assign done_out  = r_flush && (r_cnt == '0);

endmodule

// File: rtl/rob_commit_ctrl.sv
// Retirement sequencer at the ROB head: regfile writes, store commit handshake, mispredict flush.
// Optional retire/mispredict counters are built when ROB_COMMIT_STATS_EN is defined.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned Q_WIDTH        = Q_WIDTH_DEF,
  parameter int unsigned FLUSH_CYCLES   = FLUSH_CYCLES_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      head_valid,
  input  logic [Q_WIDTH-1:0]        head_q,
  input  logic                      head_is_store,
  input  logic                      head_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0] head_reg_addr,
  input  logic [31:0]               head_v,
  input  logic [31:0]               head_npc,
  input  logic [31:0]               head_pred_pc,
  output logic                      rob_pop,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [31:0]               rf_wdata,
  output logic [Q_WIDTH-1:0]        rf_wq,
  output logic                      st_req,
  output logic [Q_WIDTH-1:0]        st_q,
  input  logic                      st_ack,
  output logic                      flush,
  output logic [31:0]               redirect_pc,
  output logic [31:0]               stat_commits,
  output logic [31:0]               stat_mispredicts
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_st_req;
  logic [Q_WIDTH-1:0] r_st_q;
  logic [31:0]        r_redirect_pc;
  logic               w_store_start;
  logic               w_store_done;
  logic               w_mispredict;
  logic               w_flush_done;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_RUN;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    rob_pop       = 1'b0;
    rf_we         = 1'b0;
    w_store_start = 1'b0;
    w_store_done  = 1'b0;
    w_mispredict  = 1'b0;
    if (rdy_in) begin
      case (r_state)
        S_RUN: begin
          if (head_valid) begin
            if (head_is_store) begin
              w_store_start = 1'b1;
              w_state_next  = S_ST_WAIT;
            end else if (head_is_branch) begin
              rob_pop = 1'b1;
              if (head_npc != head_pred_pc) begin
                w_mispredict = 1'b1;
                w_state_next = S_FLUSH;
              end
            end else begin
              rob_pop = 1'b1;
              rf_we   = (head_reg_addr != '0);
            end
          end
        end
        S_ST_WAIT: begin
          // Only an ack against an outstanding request retires the store.
          if (st_ack && r_st_req) begin
            rob_pop      = 1'b1;
            w_store_done = 1'b1;
            w_state_next = S_RUN;
          end
        end
        S_FLUSH: begin
          if (w_flush_done) begin
            w_state_next = S_RUN;
          end
        end
        default: w_state_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_st_req      <= 1'b0;
      r_st_q        <= '0;
      r_redirect_pc <= '0;
    end else if (rdy_in) begin
      if (w_store_start) begin
        r_st_req <= 1'b1;
        r_st_q   <= head_q;
      end else if (w_store_done) begin
        r_st_req <= 1'b0;
      end
      if (w_mispredict) begin
        r_redirect_pc <= head_npc;
      end
    end
  end

  rob_commit_ctrl_flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (rdy_in),
    .load_in  (w_mispredict),
    .flush_out(flush),
    .done_out (w_flush_done)
  );

  assign rf_waddr    = head_reg_addr;
  assign rf_wdata    = head_v;
  assign rf_wq       = head_q;
  assign st_req      = r_st_req;
  assign st_q        = r_st_q;
  assign redirect_pc = r_redirect_pc;

`ifdef ROB_COMMIT_STATS_EN
  logic [31:0] r_stat_commits;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stat_commits     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (rob_pop) r_stat_commits <= r_stat_commits + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_commits     = r_stat_commits;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_commits     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: table-driven single-cycle commits through a
// scoreboard queue, plus hand-written store, mispredict, reset and statistics sequences.
module tb_rob_commit_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        head_valid;
  logic [3:0]  head_q;
  logic        head_is_store;
  logic        head_is_branch;
  logic [4:0]  head_reg_addr;
  logic [31:0] head_v;
  logic [31:0] head_npc;
  logic [31:0] head_pred_pc;
  logic        rob_pop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_wq;
  logic        st_req;
  logic [3:0]  st_q;
  logic        st_ack;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] stat_commits;
  logic [31:0] stat_mispredicts;

  always #5 clk_in = ~clk_in;

  rob_commit_ctrl #(
    .REG_ADDR_WIDTH(5),
    .Q_WIDTH       (4),
    .FLUSH_CYCLES  (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .head_valid      (head_valid),
    .head_q          (head_q),
    .head_is_store   (head_is_store),
    .head_is_branch  (head_is_branch),
    .head_reg_addr   (head_reg_addr),
    .head_v          (head_v),
    .head_npc        (head_npc),
    .head_pred_pc    (head_pred_pc),
    .rob_pop         (rob_pop),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .rf_wq           (rf_wq),
    .st_req          (st_req),
    .st_q            (st_q),
    .st_ack          (st_ack),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .stat_commits    (stat_commits),
    .stat_mispredicts(stat_mispredicts)
  );

`ifdef ROB_COMMIT_STATS_EN
  localparam logic [31:0] EXP_COMMITS = 32'd4;
  localparam logic [31:0] EXP_MISP    = 32'd1;
`else
  localparam logic [31:0] EXP_COMMITS = 32'd0;
  localparam logic [31:0] EXP_MISP    = 32'd0;
`endif

  typedef struct {
    logic        rdy;
    logic        valid;
    logic [3:0]  q;
    logic        store;
    logic        branch;
    logic [4:0]  addr;
    logic [31:0] v;
    logic [31:0] npc;
    logic [31:0] pred;
    logic        e_pop;
    logic        e_we;
  } vec_t;

  typedef struct {
    logic        pop;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wq;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_head(input logic valid, input logic [3:0] q, input logic store,
                          input logic branch, input logic [4:0] addr, input logic [31:0] v,
                          input logic [31:0] npc, input logic [31:0] pred);
    head_valid     = valid;
    head_q         = q;
    head_is_store  = store;
    head_is_branch = branch;
    head_reg_addr  = addr;
    head_v         = v;
    head_npc       = npc;
    head_pred_pc   = pred;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 5'd0,  32'h11111111, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 5'd7,  32'h22222222, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 5'd8,  32'h33333333, 32'h200, 32'h200, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 5'd9,  32'h44444444, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 5'd31, 32'h12345678, 32'h0, 32'h0, 1'b1, 1'b1};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    st_ack = 1'b0;
    set_head(1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

    // Reset state
    next_cycle();
    @(negedge clk_in);
    chk("reset_st_req", 32'(st_req), 32'd0);
    chk("reset_st_q", 32'(st_q), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_redirect", redirect_pc, 32'd0);
    chk("reset_pop", 32'(rob_pop), 32'd0);
    chk("reset_stat_commits", stat_commits, 32'd0);
    next_cycle();
    rst_in = 1'b0;

    // Table-driven single-cycle commits
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      rdy_in = vecs[i].rdy;
      set_head(vecs[i].valid, vecs[i].q, vecs[i].store, vecs[i].branch, vecs[i].addr,
               vecs[i].v, vecs[i].npc, vecs[i].pred);
      e.pop   = vecs[i].e_pop;
      e.we    = vecs[i].e_we;
      e.waddr = vecs[i].addr;
      e.wdata = vecs[i].v;
      e.wq    = vecs[i].q;
      sb.push_back(e);
      @(negedge clk_in);
      e = sb.pop_front();
      $display("vec %0d: rdy=%0b valid=%0b q=%0d pop=%0b we=%0b", i, rdy_in, head_valid,
               head_q, rob_pop, rf_we);
      chk($sformatf("vec%0d_pop", i), 32'(rob_pop), 32'(e.pop));
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(e.we));
      if (e.we) begin
        chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(e.waddr));
        chk($sformatf("vec%0d_wdata", i), rf_wdata, e.wdata);
        chk($sformatf("vec%0d_wq", i), 32'(rf_wq), 32'(e.wq));
      end
      next_cycle();
    end
    rdy_in = 1'b1;

    // Store: request the cycle after, held through 4 ack-less cycles, pop only on ack
    set_head(1'b1, 4'd7, 1'b1, 1'b0, 5'd3, 32'hAAAA5555, 32'h0, 32'h0);
    @(negedge clk_in);
    chk("st_c0_pop", 32'(rob_pop), 32'd0);
    chk("st_c0_req", 32'(st_req), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk_in);
      $display("store wait cycle %0d: st_req=%0b st_q=%0d pop=%0b", c, st_req, st_q, rob_pop);
      chk($sformatf("st_wait%0d_req", c), 32'(st_req), 32'd1);
      chk($sformatf("st_wait%0d_q", c), 32'(st_q), 32'd7);
      chk($sformatf("st_wait%0d_pop", c), 32'(rob_pop), 32'd0);
    end
    next_cycle();
    st_ack = 1'b1;
    @(negedge clk_in);
    chk("st_ack_pop", 32'(rob_pop), 32'd1);
    chk("st_ack_we", 32'(rf_we), 32'd0);
    chk("st_ack_req", 32'(st_req), 32'd1);
    next_cycle();
    set_head(1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_in);
    chk("st_after_req", 32'(st_req), 32'd0);
    chk("st_stray_ack_pop", 32'(rob_pop), 32'd0);
    next_cycle();
    st_ack = 1'b0;

    // Mispredict: pop, then flush + redirect for exactly two cycles with no pops
    set_head(1'b1, 4'd10, 1'b0, 1'b1, 5'd0, 32'h0, 32'h00001000, 32'h00000FFC);
    @(negedge clk_in);
    chk("mp_pop", 32'(rob_pop), 32'd1);
    chk("mp_flush_early", 32'(flush), 32'd0);
    next_cycle();
    set_head(1'b1, 4'd11, 1'b0, 1'b0, 5'd6, 32'h0BADF00D, 32'h0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_in);
      $display("flush cycle %0d: flush=%0b redirect=0x%08h pop=%0b", c, flush, redirect_pc,
               rob_pop);
      chk($sformatf("mp_flush%0d", c), 32'(flush), 32'd1);
      chk($sformatf("mp_redirect%0d", c), redirect_pc, 32'h00001000);
      chk($sformatf("mp_pop%0d", c), 32'(rob_pop), 32'd0);
      chk($sformatf("mp_we%0d", c), 32'(rf_we), 32'd0);
      next_cycle();
    end
    @(negedge clk_in);
    chk("mp_flush_end", 32'(flush), 32'd0);
    chk("mp_resume_pop", 32'(rob_pop), 32'd1);
    chk("mp_resume_we", 32'(rf_we), 32'd1);
    next_cycle();

    // Reset during ST_WAIT returns to RUN with st_req cleared
    set_head(1'b1, 4'd12, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    next_cycle();
    @(negedge clk_in);
    chk("rst_st_req_set", 32'(st_req), 32'd1);
    rst_in = 1'b1;
    next_cycle();
    rst_in = 1'b0;
    set_head(1'b1, 4'd13, 1'b0, 1'b0, 5'd2, 32'h55AA55AA, 32'h0, 32'h0);
    @(negedge clk_in);
    chk("rst_st_req_clr", 32'(st_req), 32'd0);
    chk("rst_run_pop", 32'(rob_pop), 32'd1);
    next_cycle();

    // Statistics: 3 commits plus 1 mispredict after a fresh reset
    rst_in = 1'b1;
    set_head(1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    next_cycle();
    rst_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_head(1'b1, 4'(c + 1), 1'b0, 1'b0, 5'd1, 32'(c), 32'h0, 32'h0);
      next_cycle();
    end
    set_head(1'b1, 4'd4, 1'b0, 1'b1, 5'd0, 32'h0, 32'h00002000, 32'h00002004);
    next_cycle();
    set_head(1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) next_cycle();
    @(negedge clk_in);
    $display("stats: commits=%0d mispredicts=%0d", stat_commits, stat_mispredicts);
    chk("stat_commits", stat_commits, EXP_COMMITS);
    chk("stat_mispredicts", stat_mispredicts, EXP_MISP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
